hb_up2_int2: RTL and testbench

//  Half-band interpolate-by-2 FIR for 2 time-interleaved channels (int2); datapath stage of the up-conversion chain.
//  - Channel 0 occupies even clock slots, channel 1 odd slots. Each channel has one sample per 2 clocks.
//  - Each input sample produces two output phases in the same slot: yout0 (centre-tap/pass-through), yout1 (FIR phase).

---
 rtl/hb_up2_pkg.sv | 60 ++++++
 rtl/hb_up2_preadd_mac.sv | 50 +++++
 rtl/hb_up2_int2.sv | 169 ++++++++++++++++
 tb/tb_hb_up2_int2.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hb_up2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hb_up2_pkg
//  Brief    : Shared defaults, derived widths and the output range check for
//             the two-channel half-band interpolate-by-2 filter.
//  Revision : 1.0  initial release
// ============================================================================
package hb_up2_pkg;

  // Default datapath geometry
  localparam int DEF_XIN_WIDTH      = 16;
  localparam int DEF_COE_WIDTH      = 16;
  localparam int DEF_NUM_UNIQUE_COE = 5;
  localparam int DEF_YOUT_WIDTH     = 16;
  localparam int DEF_SRA_BITS       = 15;

  // Unique non-centre taps, outermost first, Q15
  typedef logic signed [DEF_COE_WIDTH-1:0] coe_arr_t [DEF_NUM_UNIQUE_COE];
  localparam coe_arr_t DEF_COE_NUMS = '{16'sd952, -16'sd1609, 16'sd3090,
                                        -16'sd6260, 16'sd20622};

  // Outcome of comparing a rounded result with the signed output range
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_dir_e;

  // Symmetric pre-add needs one growth bit so -2^(W-1) + -2^(W-1) fits
  function automatic int calc_pre_w(input int xin_w);
    return xin_w + 1;
  endfunction

  function automatic int calc_prod_w(input int xin_w, input int coe_w);
    return calc_pre_w(xin_w) + coe_w;
  endfunction

  // Accumulator grows by clog2 of the number of summed products
  function automatic int calc_acc_w(input int xin_w, input int coe_w, input int n);
    return calc_prod_w(xin_w, coe_w) + $clog2(n);
  endfunction

  // Classifies an already rounded and shifted value against a yw-bit signed
  // range; the caller decides whether to clamp or wrap.
  function automatic sat_dir_e sat_round(input logic signed [63:0] v, input int yw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (yw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (yw - 1));
    if (v > hi) begin
      return SAT_HI;
    end
    if (v < lo) begin
      return SAT_LO;
    end
    return SAT_NONE;
  endfunction

endpackage : hb_up2_pkg
`default_nettype wire

// File: rtl/hb_up2_preadd_mac.sv
`default_nettype none
// ============================================================================
//  Module   : hb_up2_preadd_mac
//  Brief    : One symmetric tap pair: registered pre-add of the two mirrored
//             samples followed by a registered multiply by the tap weight.
//  Revision : 1.0  initial release
// ============================================================================
module hb_up2_preadd_mac
  import hb_up2_pkg::*;
#(
  parameter int                          XIN_WIDTH = DEF_XIN_WIDTH,
  parameter int                          COE_WIDTH = DEF_COE_WIDTH,
  parameter logic signed [COE_WIDTH-1:0] COE       = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [XIN_WIDTH-1:0]           xa_i,
  input  logic signed [XIN_WIDTH-1:0]           xb_i,
  output logic signed [XIN_WIDTH+COE_WIDTH:0]   prod_o
);

  localparam int PRE_W  = calc_pre_w(XIN_WIDTH);
  localparam int PROD_W = calc_prod_w(XIN_WIDTH, COE_WIDTH);

  logic signed [PRE_W-1:0]  pre_d;
  logic signed [PRE_W-1:0]  pre_q;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;

  // Widen before adding so the mirrored pair never wraps
  always_comb begin
    pre_d  = PRE_W'(xa_i) + PRE_W'(xb_i);
    prod_d = PROD_W'(pre_q) * PROD_W'(COE);
  end

  // Two pipeline registers: pre-add result, then product
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      prod_q <= '0;
    end else begin
      pre_q  <= pre_d;
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule : hb_up2_preadd_mac
`default_nettype wire

// File: rtl/hb_up2_int2.sv
`default_nettype none
// ============================================================================
//  Module   : hb_up2_int2
//  Brief    : Half-band interpolate-by-2 FIR for two time-interleaved
//             channels (ch0 even slots, ch1 odd slots). Each input produces a
//             pass-through phase (yout0) and an FIR phase (yout1), 6 clocks
//             after the sample, in the same slot parity.
//  Config   : HB_UP2_INT2_SAT_EN defined   -> outputs saturate
//             HB_UP2_INT2_SAT_EN undefined -> outputs wrap; ovf still flags
//  Revision : 1.0  initial release
// ============================================================================
module hb_up2_int2
  import hb_up2_pkg::*;
#(
  parameter int                          XIN_WIDTH      = DEF_XIN_WIDTH,
  parameter int                          COE_WIDTH      = DEF_COE_WIDTH,
  parameter int                          NUM_UNIQUE_COE = DEF_NUM_UNIQUE_COE,
  parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] = DEF_COE_NUMS,
  parameter int                          YOUT_WIDTH     = DEF_YOUT_WIDTH,
  parameter int                          SRA_BITS       = DEF_SRA_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [XIN_WIDTH-1:0]   xin,
  output logic signed [YOUT_WIDTH-1:0]  yout0,
  output logic signed [YOUT_WIDTH-1:0]  yout1,
  output logic                          ovf
);

  localparam int N       = NUM_UNIQUE_COE;
  localparam int PROD_W  = calc_prod_w(XIN_WIDTH, COE_WIDTH);
  localparam int ACC_W   = calc_acc_w(XIN_WIDTH, COE_WIDTH, NUM_UNIQUE_COE);
  localparam int NP      = (N + 1) / 2;
  // Interleaved delay line: every second register belongs to the same
  // channel, so tap k of a channel sits at index 2k. It must reach both the
  // oldest FIR tap (4N-2) and the centre tap aligned to the rounding stage.
  localparam int SR_LEN  = ((4*N - 1) > (2*N + 5)) ? (4*N - 1) : (2*N + 5);
  // x[i-N] sits at index 2N right after sampling; four pipeline stages later
  // (pre-add, product, pair sum, accumulate) it has moved to 2N+4.
  localparam int CTR_IDX = 2*N + 4;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd1 <<< (SRA_BITS - 1));
`ifdef HB_UP2_INT2_SAT_EN
  localparam logic signed [YOUT_WIDTH-1:0] Y_MAX = {1'b0, {(YOUT_WIDTH-1){1'b1}}};
  localparam logic signed [YOUT_WIDTH-1:0] Y_MIN = {1'b1, {(YOUT_WIDTH-1){1'b0}}};
`endif

  logic signed [XIN_WIDTH-1:0]  sr_q [SR_LEN];
  logic signed [PROD_W-1:0]     tap_prod [N];
  logic signed [ACC_W-1:0]      psum_d [NP];
  logic signed [ACC_W-1:0]      psum_q [NP];
  logic signed [ACC_W-1:0]      acc_d;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      rs_d;
  logic signed [ACC_W-1:0]      rs_q;
  logic signed [XIN_WIDTH-1:0]  c_q;
  sat_dir_e                     dir0;
  sat_dir_e                     dir1;
  logic signed [YOUT_WIDTH-1:0] yout0_d;
  logic signed [YOUT_WIDTH-1:0] yout1_d;
  logic                         ovf_d;
  logic signed [YOUT_WIDTH-1:0] yout0_q;
  logic signed [YOUT_WIDTH-1:0] yout1_q;
  logic                         ovf_q;

  // Shared interleaved delay line; the two channels alternate registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SR_LEN; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      sr_q[0] <= xin;
      for (int k = 1; k < SR_LEN; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  // Tap m pairs x[i-m] with its mirror x[i-(2N-1)+m]
  for (genvar m = 0; m < N; m++) begin : g_tap
    hb_up2_preadd_mac #(
      .XIN_WIDTH (XIN_WIDTH),
      .COE_WIDTH (COE_WIDTH),
      .COE       (COE_NUMS[m])
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .xa_i   (sr_q[2*m]),
      .xb_i   (sr_q[4*N - 2 - 2*m]),
      .prod_o (tap_prod[m])
    );
  end

  // First adder-tree level: neighbouring products summed in pairs
  for (genvar p = 0; p < NP; p++) begin : g_pair
    if (2*p + 1 < N) begin : g_two
      assign psum_d[p] = ACC_W'(tap_prod[2*p]) + ACC_W'(tap_prod[2*p + 1]);
    end else begin : g_one
      assign psum_d[p] = ACC_W'(tap_prod[2*p]);
    end
  end

  // Second adder-tree level plus round-half-up bias and shift
  always_comb begin
    acc_d = '0;
    for (int p = 0; p < NP; p++) begin
      acc_d = acc_d + psum_q[p];
    end
    rs_d = (acc_q + RND_HALF) >>> SRA_BITS;
  end

  // Adder tree, rounding and centre-tap alignment registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        psum_q[p] <= '0;
      end
      acc_q <= '0;
      rs_q  <= '0;
      c_q   <= '0;
    end else begin
      psum_q <= psum_d;
      acc_q  <= acc_d;
      rs_q   <= rs_d;
      // Centre tap scaled by 2^SRA_BITS then rounded back is the sample itself
      c_q    <= sr_q[CTR_IDX];
    end
  end

  // Range check of both phases, then clamp or wrap to the output width
  always_comb begin
    dir1    = sat_round(64'(rs_q), YOUT_WIDTH);
    dir0    = sat_round(64'(c_q), YOUT_WIDTH);
    ovf_d   = (dir0 != SAT_NONE) || (dir1 != SAT_NONE);
    yout1_d = YOUT_WIDTH'(rs_q);
    yout0_d = YOUT_WIDTH'(c_q);
`ifdef HB_UP2_INT2_SAT_EN
    if (dir1 == SAT_HI) begin
      yout1_d = Y_MAX;
    end else if (dir1 == SAT_LO) begin
      yout1_d = Y_MIN;
    end
    if (dir0 == SAT_HI) begin
      yout0_d = Y_MAX;
    end else if (dir0 == SAT_LO) begin
      yout0_d = Y_MIN;
    end
`endif
  end

  // Registered outputs; ovf reflects only the current slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      yout0_q <= '0;
      yout1_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      yout0_q <= yout0_d;
      yout1_q <= yout1_d;
      ovf_q   <= ovf_d;
    end
  end

  assign yout0 = yout0_q;
  assign yout1 = yout1_q;
  assign ovf   = ovf_q;

endmodule : hb_up2_int2
`default_nettype wire

// File: tb/tb_hb_up2_int2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hb_up2_int2
//  Brief    : Self-checking bench for hb_up2_int2 with a direct-formula
//             reference model of both channels.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hb_up2_int2;

  localparam int N    = 5;
  localparam int EMAX = 20000;
  localparam longint COE [N] = '{952, -1609, 3090, -6260, 20622};
  localparam longint IMP_Y1 [10] = '{119, -201, 386, -782, 2578, 2578, -782, 386, -201, 119};
`ifdef HB_UP2_INT2_SAT_EN
  localparam longint DC_POS_Y1 = 32767;
  localparam longint DC_NEG_Y1 = -32768;
`else
  localparam longint DC_POS_Y1 = 33589 - 65536;
  localparam longint DC_NEG_Y1 = -33590 + 65536;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] xin = '0;
  logic signed [15:0] yout0;
  logic signed [15:0] yout1;
  logic               ovf;

  int     n_tests  = 0;
  int     n_fail   = 0;
  int     e        = 0;
  bit     checking = 1'b0;
  int     imp_edge = -1;
  longint hist [2][2*N];
  logic signed [63:0] exp_y0 [EMAX];
  logic signed [63:0] exp_y1 [EMAX];
  logic signed [63:0] exp_ov [EMAX];

  always #5 clk = ~clk;

  hb_up2_int2 dut (
    .clk   (clk),
    .rst   (rst),
    .xin   (xin),
    .yout0 (yout0),
    .yout1 (yout1),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0d expected %0d", tag, e, got, expv);
    end
  endtask

  // Ideal value -> output word, flagging anything outside 16-bit signed
  function automatic longint fit_y(input longint v, output bit o);
`ifndef HB_UP2_INT2_SAT_EN
    logic signed [15:0] t;
`endif
    o = (v > 32767) || (v < -32768);
`ifdef HB_UP2_INT2_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = 16'(v);
    return longint'(t);
`endif
  endfunction

  // Reference: per-channel sample history and the filter equation
  task automatic model(input longint x, input bit r);
    longint acc;
    longint r1;
    longint y0;
    longint y1;
    bit     o0;
    bit     o1;
    int     ch;
    if (!r) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 2*N; k++) hist[c][k] = 0;
      for (int k = 0; k <= 6; k++) begin
        exp_y0[e+k] = 0;
        exp_y1[e+k] = 0;
        exp_ov[e+k] = 0;
      end
    end else begin
      ch = e % 2;
      for (int k = 2*N - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = x;
      acc = 0;
      for (int m = 0; m < N; m++) acc += COE[m] * (hist[ch][m] + hist[ch][2*N-1-m]);
      r1 = (acc + 16384) >>> 15;
      y1 = fit_y(r1, o1);
      y0 = fit_y(hist[ch][N], o0);
      exp_y1[e+6] = y1;
      exp_y0[e+6] = y0;
      exp_ov[e+6] = (o0 || o1) ? 64'sd1 : 64'sd0;
    end
  endtask

  function automatic longint rnd_x();
    logic signed [15:0] v;
    int unsigned        s;
    s = $urandom_range(0, 15);
    if (s == 0) return -32768;
    if (s == 1) return 32767;
    v = 16'($urandom);
    return longint'(v);
  endfunction

  // One clock: drive, wait for the edge, update model, compare outputs
  task automatic step(input longint x, input bit r);
    int d;
    if (e + 7 >= EMAX) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, EMAX - 7);
      $fatal(1, "edge budget exhausted");
    end
    xin = 16'(x);
    rst = r;
    @(posedge clk);
    #1;
    model(x, r);
    if (!r) checking = 1'b1;
    if (checking) begin
      chk("yout0", yout0, exp_y0[e]);
      chk("yout1", yout1, exp_y1[e]);
      chk("ovf", ovf, exp_ov[e]);
    end
    if (imp_edge >= 0) begin
      d = e - imp_edge;
      if (d >= 6 && d <= 24 && (d % 2) == 0) chk("imp_yout1", yout1, IMP_Y1[(d-6)/2]);
      if (d >= 6 && d <= 24 && (d % 2) == 1) chk("imp_other_slot", yout1, 0);
      if (d == 16) chk("imp_yout0", yout0, 4096);
    end
    e++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) step(0, 1'b0);
    for (int k = 0; k < 4; k++) step(0, 1'b1);

    // Impulse on channel 0
    if (e % 2 != 0) step(0, 1'b1);
    imp_edge = e;
    step(4096, 1'b1);
    for (int k = 0; k < 30; k++) step(0, 1'b1);

    // Impulse on channel 1
    if (e % 2 == 0) step(0, 1'b1);
    imp_edge = e;
    step(4096, 1'b1);
    for (int k = 0; k < 30; k++) step(0, 1'b1);
    imp_edge = -1;

    // Positive full-scale DC on channel 0
    if (e % 2 != 0) step(0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      step((k % 2 == 0) ? 32767 : 0, 1'b1);
      if (k == 58) begin
        chk("dc_pos_yout1", yout1, DC_POS_Y1);
        chk("dc_pos_yout0", yout0, 32767);
        chk("dc_pos_ovf", ovf, 1);
      end
      if (k == 59) chk("dc_pos_ch1", yout1, 0);
    end
    for (int k = 0; k < 30; k++) step(0, 1'b1);

    // Negative full-scale DC on channel 0
    if (e % 2 != 0) step(0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      step((k % 2 == 0) ? -32768 : 0, 1'b1);
      if (k == 58) begin
        chk("dc_neg_yout1", yout1, DC_NEG_Y1);
        chk("dc_neg_yout0", yout0, -32768);
        chk("dc_neg_ovf", ovf, 1);
      end
      if (k == 59) chk("dc_neg_ch1", yout1, 0);
    end
    for (int k = 0; k < 30; k++) step(0, 1'b1);

    // Random 4096-sample channel-0 stream, channel 1 silent
    if (e % 2 != 0) step(0, 1'b1);
    for (int k = 0; k < 8192; k++) step((k % 2 == 0) ? rnd_x() : 0, 1'b1);

    // Both channels random
    for (int k = 0; k < 400; k++) step(rnd_x(), 1'b1);

    // Mid-stream reset for one clock, then impulse on a cleared filter
    for (int k = 0; k < 21; k++) step(rnd_x(), 1'b1);
    step(rnd_x(), 1'b0);
    if (e % 2 != 0) step(0, 1'b1);
    imp_edge = e;
    step(4096, 1'b1);
    for (int k = 0; k < 30; k++) step(0, 1'b1);
    imp_edge = -1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hb_up2_int2
`default_nettype wire
